i2c_sensor_poller: RTL and testbench

I2C_SENSOR_POLLER -- requirements
Module: i2c_sensor_poller

---
 rtl/sensor_pkg.sv | 57 +++++
 rtl/sync_2ff.sv | 26 ++
 rtl/i2c_sensor_poller.sv | 197 +++++++++++++++++++
 tb/tb_i2c_sensor_poller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared state encoding, request operand bundle and default register constants
// for the I2C sensor poller. SENSOR_CFG_WRITE_EN adds the config-write states.
package sensor_pkg;

    localparam logic [6:0] DEF_SENSOR_ADDR = 7'h48;
    localparam logic [7:0] DEF_PTR_REG     = 8'h00;
`ifdef SENSOR_CFG_WRITE_EN
    localparam logic [7:0] DEF_CFG_REG     = 8'h01;
    localparam logic [7:0] DEF_CFG_VAL     = 8'h60;

    typedef enum logic [3:0] {
        IDLE, CFG_REQ, CFG_WAIT, PTR_REQ, PTR_WAIT,
        RDH_REQ, RDH_WAIT, RDL_REQ, RDL_WAIT, DONE
    } state_t;
    localparam state_t RESET_STATE = CFG_REQ;
`else
    typedef enum logic [3:0] {
        IDLE, PTR_REQ, PTR_WAIT, RDH_REQ, RDH_WAIT, RDL_REQ, RDL_WAIT, DONE
    } state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    typedef struct packed {
        logic       rw;
        logic [7:0] data;
        logic [7:0] data_2;
        logic       ena_w_data_2;
    } req_ops_t;

    function automatic logic is_req_state(state_t s);
        logic r;
        r = (s == PTR_REQ) || (s == RDH_REQ) || (s == RDL_REQ);
`ifdef SENSOR_CFG_WRITE_EN
        r = r || (s == CFG_REQ);
`endif
        return r;
    endfunction

    // States that own a controller handshake and are therefore subject to the timeout.
    function automatic logic is_phase_state(state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

    function automatic state_t wait_of(state_t s);
        state_t w;
        case (s)
`ifdef SENSOR_CFG_WRITE_EN
            CFG_REQ: w = CFG_WAIT;
`endif
            PTR_REQ: w = PTR_WAIT;
            RDH_REQ: w = RDH_WAIT;
            default: w = RDL_WAIT;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2c_sensor_poller.sv
// Periodically reads a 16-bit register from an I2C sensor through a byte-level controller.
// Define SENSOR_CFG_WRITE_EN to add a one-shot config register write after reset / config timeout.
module i2c_sensor_poller
    import sensor_pkg::*;
#(
    parameter logic [6:0]  SENSOR_ADDR = DEF_SENSOR_ADDR,
    parameter logic [7:0]  PTR_REG     = DEF_PTR_REG,
`ifdef SENSOR_CFG_WRITE_EN
    parameter logic [7:0]  CFG_REG     = DEF_CFG_REG,
    parameter logic [7:0]  CFG_VAL     = DEF_CFG_VAL,
`endif
    parameter int unsigned POLL_PERIOD = 100000,
    parameter int unsigned TIMEOUT     = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll_en,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic        busy,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_data_in,
    output logic [7:0]  i2c_data_in_2,
    output logic        i2c_ena_w_data_2,
    output logic        i2c_enable,
    input  logic [7:0]  i2c_data_out,
    input  logic        i2c_ready
);

    localparam logic [31:0] PERIOD_LAST  = 32'(POLL_PERIOD - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    logic        ready_s;
    logic [31:0] per_cnt_q;
    logic        wrap;

    state_t      state_q;
    logic [31:0] phase_q;
    logic        en_q;
    req_ops_t    ops_q;
    logic [7:0]  msb_q;
    logic [7:0]  lsb_q;
    logic [15:0] sample_q;
    logic        svld_q;
    logic        err_q;
    logic [7:0]  errcnt_q;
`ifdef SENSOR_CFG_WRITE_EN
    logic        cfg_pend_q;
`endif

    function automatic req_ops_t ops_for(state_t s);
        req_ops_t o;
        o = '0;
        case (s)
`ifdef SENSOR_CFG_WRITE_EN
            CFG_REQ: begin
                o.data         = CFG_REG;
                o.data_2       = CFG_VAL;
                o.ena_w_data_2 = 1'b1;
            end
`endif
            PTR_REQ:          o.data = PTR_REG;
            RDH_REQ, RDL_REQ: o.rw   = 1'b1;
            default:          o      = '0;
        endcase
        return o;
    endfunction

    sync_2ff #(.WIDTH(1)) u_ready_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (i2c_ready),
        .q_o   (ready_s)
    );

    // Free-running poll timer; a wrap is only a one-cycle hint, never remembered.
    assign wrap = poll_en && (per_cnt_q == PERIOD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
        end else if (!poll_en || wrap) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            phase_q    <= '0;
            en_q       <= 1'b0;
            ops_q      <= '0;
            msb_q      <= '0;
            lsb_q      <= '0;
            sample_q   <= '0;
            svld_q     <= 1'b0;
            err_q      <= 1'b0;
            errcnt_q   <= '0;
`ifdef SENSOR_CFG_WRITE_EN
            cfg_pend_q <= 1'b0;
`endif
        end else begin
            svld_q  <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= phase_q + 32'd1;
            if (is_phase_state(state_q) && (phase_q >= TIMEOUT_LAST)) begin
                state_q <= IDLE;
                phase_q <= '0;
                en_q    <= 1'b0;
                err_q   <= 1'b1;
                if (errcnt_q != 8'hFF) begin
                    errcnt_q <= errcnt_q + 8'd1;
                end
`ifdef SENSOR_CFG_WRITE_EN
                if ((state_q == CFG_REQ) || (state_q == CFG_WAIT)) begin
                    cfg_pend_q <= 1'b1;
                end
`endif
            end else if (is_req_state(state_q)) begin
                // Only raise enable once the controller reports idle, so a request issued
                // straight after reset never mistakes the cleared synchroniser for an accept.
                if (!en_q) begin
                    if (ready_s) begin
                        en_q  <= 1'b1;
                        ops_q <= ops_for(state_q);
                    end
                end else if (!ready_s) begin
                    en_q    <= 1'b0;
                    state_q <= wait_of(state_q);
                    phase_q <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        phase_q <= '0;
                        if (wrap) begin
`ifdef SENSOR_CFG_WRITE_EN
                            state_q <= cfg_pend_q ? CFG_REQ : PTR_REQ;
`else
                            state_q <= PTR_REQ;
`endif
                        end
                    end
`ifdef SENSOR_CFG_WRITE_EN
                    CFG_WAIT: if (ready_s) begin
                        state_q    <= IDLE;
                        phase_q    <= '0;
                        cfg_pend_q <= 1'b0;
                    end
`endif
                    PTR_WAIT: if (ready_s) begin
                        state_q <= RDH_REQ;
                        phase_q <= '0;
                    end
                    RDH_WAIT: if (ready_s) begin
                        msb_q   <= i2c_data_out;
                        state_q <= RDL_REQ;
                        phase_q <= '0;
                    end
                    RDL_WAIT: if (ready_s) begin
                        lsb_q   <= i2c_data_out;
                        state_q <= DONE;
                        phase_q <= '0;
                    end
                    DONE: begin
                        sample_q <= {msb_q, lsb_q};
                        svld_q   <= 1'b1;
                        state_q  <= IDLE;
                        phase_q  <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        phase_q <= '0;
                    end
                endcase
            end
        end
    end

    assign sample           = sample_q;
    assign sample_valid     = svld_q;
    assign err              = err_q;
    assign err_cnt          = errcnt_q;
    assign busy             = (state_q != IDLE);
    assign i2c_addr         = SENSOR_ADDR;
    assign i2c_rw           = ops_q.rw;
    assign i2c_data_in      = ops_q.data;
    assign i2c_data_in_2    = ops_q.data_2;
    assign i2c_ena_w_data_2 = ops_q.ena_w_data_2;
    assign i2c_enable       = en_q;

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Scoreboard bench for i2c_sensor_poller: a behavioural I2C controller/sensor model
// supplies random readings; a monitor checks every sample, error pulse and counter.
`timescale 1ns/1ps
module tb_i2c_sensor_poller;

    localparam int         PERIOD = 64;
    localparam int         TMO    = 100;
    localparam logic [6:0] ADDR   = 7'h48;
    localparam logic [7:0] PTR    = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_en = 1'b0;
    logic [15:0] sample;
    logic        sample_valid, err, busy;
    logic [7:0]  err_cnt;
    logic [6:0]  i2c_addr;
    logic        i2c_rw, i2c_ena_w_data_2, i2c_enable;
    logic [7:0]  i2c_data_in, i2c_data_in_2;
    logic [7:0]  i2c_data_out = 8'h00;
    logic        i2c_ready = 1'b1;

    int n_cmp = 0, n_fail = 0;
    int n_samples = 0, n_err = 0, n_acc = 0, n_cfg = 0;
    logic [15:0] exp_q[$];

    // Controller / sensor model state
    bit          stuck = 1'b0;
    int          hold_low = 0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    int          m_kind = 0;  // 0 cfg write, 1 pointer write, 2 read
    int          rd_idx = 2;
    int          fixed_left = 3;
    logic [15:0] cur_val = 16'h0;

    i2c_sensor_poller #(
        .POLL_PERIOD (PERIOD),
        .TIMEOUT     (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .poll_en          (poll_en),
        .sample           (sample),
        .sample_valid     (sample_valid),
        .err              (err),
        .err_cnt          (err_cnt),
        .busy             (busy),
        .i2c_addr         (i2c_addr),
        .i2c_rw           (i2c_rw),
        .i2c_data_in      (i2c_data_in),
        .i2c_data_in_2    (i2c_data_in_2),
        .i2c_ena_w_data_2 (i2c_ena_w_data_2),
        .i2c_enable       (i2c_enable),
        .i2c_data_out     (i2c_data_out),
        .i2c_ready        (i2c_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level controller: accepts when idle and enabled, stays busy a few cycles,
    // then returns to ready with read data. The sensor serves a 16-bit reading MSB first.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                m_busy    = 1'b0;
                i2c_ready = (hold_low == 0);
            end else if (hold_low > 0) begin
                i2c_ready = 1'b0;
                hold_low--;
            end else if (stuck) begin
                i2c_ready = 1'b1;
                m_busy    = 1'b0;
            end else if (!m_busy) begin
                i2c_ready = 1'b1;
                if (i2c_enable) begin
                    n_acc++;
                    check("addr", 32'(i2c_addr), 32'(ADDR));
                    if (!i2c_rw && i2c_ena_w_data_2) begin
                        m_kind = 0;
                        n_cfg++;
                        check("cfg_reg", 32'(i2c_data_in), 32'h01);
                        check("cfg_val", 32'(i2c_data_in_2), 32'h60);
                    end else if (!i2c_rw) begin
                        m_kind = 1;
                        check("ptr_reg", 32'(i2c_data_in), 32'(PTR));
                    end else begin
                        m_kind = 2;
                        check("read_order", 32'(rd_idx < 2), 32'd1);
                    end
                    m_busy    = 1'b1;
                    m_cnt     = $urandom_range(4, 9);
                    i2c_ready = 1'b0;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
            end else begin
                if (m_kind == 1) begin
                    rd_idx  = 0;
                    cur_val = (fixed_left > 0) ? 16'h1AC3 : 16'($urandom);
                    if (fixed_left > 0) fixed_left--;
                    exp_q.push_back(cur_val);
                end else if (m_kind == 2) begin
                    i2c_data_out = (rd_idx == 0) ? cur_val[15:8] : cur_val[7:0];
                    rd_idx++;
                end
                m_busy    = 1'b0;
                i2c_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sample_valid || err) check("valid_err_exclusive", 32'(sample_valid & err), 32'd0);
                if (sample_valid) begin
                    n_samples++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sample_unexpected: got %0h expected none", sample);
                    end else begin
                        check("sample", 32'(sample), 32'(exp_q.pop_front()));
                    end
                end
                if (err) begin
                    n_err++;
                    check("err_cnt", 32'(err_cnt), (n_err > 255) ? 32'd255 : 32'(n_err));
                    check("err_enable_low", 32'(i2c_enable), 32'd0);
                end
            end
        end
    end

    task automatic wait_samples(input int k, input int budget);
        int target;
        int c;
        target = n_samples + k;
        c = 0;
        while (n_samples < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("wait_samples_in_budget", 32'(n_samples >= target), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_sample"}, 32'(sample), 32'd0);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_enable"}, 32'(i2c_enable), 32'd0);
        check({tag, "_rw"}, 32'(i2c_rw), 32'd0);
        check({tag, "_data_in"}, 32'(i2c_data_in), 32'd0);
        check({tag, "_data_in_2"}, 32'(i2c_data_in_2), 32'd0);
        check({tag, "_ena_w2"}, 32'(i2c_ena_w_data_2), 32'd0);
        check({tag, "_addr"}, 32'(i2c_addr), 32'(ADDR));
`ifdef SENSOR_CFG_WRITE_EN
        check({tag, "_busy"}, 32'(busy), 32'd1);
`else
        check({tag, "_busy"}, 32'(busy), 32'd0);
`endif
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, start, acc0, bad;
        logic [15:0] keep;

        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SENSOR_CFG_WRITE_EN
        c = 0;
        while (busy && c < 300) begin @(negedge clk); c++; end
        check("cfg_done_idle", 32'(busy), 32'd0);
        check("cfg_write_count", 32'(n_cfg), 32'd1);
`endif

        // Periodic polling, fixed reading first, then random readings
        poll_en = 1'b1;
        wait_samples(1, 4 * PERIOD);
        check("first_sample_1AC3", 32'(sample), 32'h1AC3);
        start = n_samples;
        repeat (PERIOD * 20 - 32) @(posedge clk);
        check("one_sample_per_period", 32'(n_samples - start), 32'd19);
        wait_samples(10, 12 * PERIOD);

        // Drop poll_en while the MSB read is in flight
        c = 0;
        while (!(m_busy && m_kind == 2 && rd_idx == 0) && c < 4 * PERIOD) begin @(negedge clk); c++; end
        check("reach_rdh", 32'(c < 4 * PERIOD), 32'd1);
        repeat (4) @(negedge clk);
        poll_en = 1'b0;
        start = n_samples;
        wait_samples(1, 2 * PERIOD);
        acc0 = n_acc;
        repeat (5 * PERIOD) @(negedge clk);
        check("drop_one_sample", 32'(n_samples - start), 32'd1);
        check("drop_no_new_polls", 32'(n_acc - acc0), 32'd0);
        check("drop_idle", 32'(busy), 32'd0);

        // Reset during the LSB read; controller stays busy for a while after release
        poll_en = 1'b1;
        c = 0;
        while (!(m_busy && m_kind == 2 && rd_idx == 1) && c < 4 * PERIOD) begin @(negedge clk); c++; end
        check("reach_rdl", 32'(c < 4 * PERIOD), 32'd1);
        repeat (4) @(posedge clk);
        #3;
        hold_low = 80;
        rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        exp_q.delete();
        n_err = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        c = 0;
        while (hold_low > 0 && c < 200) begin
            @(negedge clk);
            if (!i2c_ready && i2c_enable) bad++;
            c++;
        end
        check("no_enable_while_not_ready", 32'(bad), 32'd0);
        wait_samples(3, 8 * PERIOD);

        // Controller never accepts: every poll times out
        c = 0;
        while (busy && c < 2 * PERIOD) begin @(negedge clk); c++; end
        stuck = 1'b1;
        keep = sample;
        start = n_samples;
        c = 0;
        while (!i2c_enable && c < 3 * PERIOD) begin @(negedge clk); c++; end
        c = 0;
        while (!err && c < TMO + 20) begin @(negedge clk); c++; end
        check("timeout_latency_ok", 32'((c >= TMO - 4) && (c <= TMO + 3)), 32'd1);
        check("timeout_err_cnt_1", 32'(err_cnt), 32'd1);
        check("timeout_enable_low", 32'(i2c_enable), 32'd0);
        check("timeout_sample_kept", 32'(sample), 32'(keep));
        c = 0;
        while (n_err < 300 && c < 300 * (2 * PERIOD + TMO)) begin @(negedge clk); c++; end
        check("timeouts_reached_300", 32'(n_err), 32'd300);
        check("err_cnt_saturated", 32'(err_cnt), 32'hFF);
        check("stuck_sample_kept", 32'(sample), 32'(keep));
        check("stuck_no_samples", 32'(n_samples - start), 32'd0);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef SENSOR_CFG_WRITE_EN
        check("cfg_writes_total", 32'(n_cfg), 32'd2);
`else
        check("cfg_writes_total", 32'(n_cfg), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
